// File: rtl/srv_icache.sv
// srv_icache: direct-mapped instruction cache for the schoolRISCV fetch stage.
// Word fetches are served combinationally from a local line store. On a miss
// the block requests a 128-bit line over ext_req/ext_rsp, writes it into the
// latched index and resumes lookup. Only one fill is outstanding at a time.
module srv_icache #(
    parameter int LINES = 16
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         cpu_req_i,
    input  logic [31:0]  cpu_addr_i,
    output logic         cpu_valid_o,
    output logic [31:0]  cpu_rdata_o,
    output logic         cpu_stall_o,

    input  logic         inv_i,

    output logic         ext_req_o,
    output logic [31:0]  ext_addr_o,
    input  logic         ext_rsp_i,
    input  logic [127:0] ext_data_i,

    output logic [15:0]  miss_cnt_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    // Refill controller states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // ------------------------------------------------------------------
    // Address split of the incoming fetch address (word address).
    // ------------------------------------------------------------------
    logic [1:0]       cpu_off;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;

    assign cpu_off = cpu_addr_i[1:0];
    assign cpu_idx = cpu_addr_i[IDX_W+1:2];
    assign cpu_tag = cpu_addr_i[31:IDX_W+2];

    // ------------------------------------------------------------------
    // State and storage.
    // ------------------------------------------------------------------
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [127:0]     data_mem [LINES];

    // Line address (word address >> 2) of the fill in flight; it drives
    // ext_addr_o and stays put until the controller returns to IDLE.
    logic [29:0]      fill_line_q;
    logic             drop_q;
    logic [15:0]      miss_cnt_q;

    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_we;

    assign fill_idx = fill_line_q[IDX_W-1:0];
    assign fill_tag = fill_line_q[29:IDX_W];

    // A response only counts while the controller is waiting for one.
    assign fill_we  = (state_q == ST_WAIT) && ext_rsp_i;

    // ------------------------------------------------------------------
    // Lookup path: purely combinational from cpu_addr_i.
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] rd_tag;
    logic [127:0]     rd_line;
    logic [31:0]      rd_word;
    logic             hit;
    logic             miss;

    // Tag compare and word select for the presented address.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        rd_tag  = tag_mem[cpu_idx];
        rd_line = data_mem[cpu_idx];
        rd_word = rd_line[{cpu_off, 5'b00000} +: 32];
        hit     = 1'b0;
        miss    = 1'b0;
        if (cpu_req_i && (state_q == ST_IDLE)) begin
            if (valid_q[cpu_idx] && (rd_tag == cpu_tag)) begin
                hit = 1'b1;
            end else begin
                miss = 1'b1;
            end
        end
    end

    assign cpu_valid_o = hit;
    assign cpu_rdata_o = hit ? rd_word : 32'd0;
    assign cpu_stall_o = cpu_req_i & ~hit;

    // ------------------------------------------------------------------
    // Refill controller.
    // ------------------------------------------------------------------

    // Next-state logic: IDLE -> REQ on a miss, REQ -> WAIT after the one
    // request cycle, WAIT -> IDLE when the line arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (miss)      state_d = ST_REQ;
            ST_REQ:                 state_d = ST_WAIT;
            ST_WAIT: if (ext_rsp_i) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any fill in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples its inputs from before the edge, independent of the
            // order in which always blocks are evaluated.
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the missing line address and count the miss (saturating).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_line_q <= '0;
            miss_cnt_q  <= '0;
        end else if (miss) begin
            fill_line_q <= cpu_addr_i[31:2];
            if (miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    // An invalidate during a fill marks the returning line as stale; the
    // mark is dropped once the controller is back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else if (fill_we) begin
            drop_q <= 1'b0;
        end else if (inv_i && (state_q != ST_IDLE)) begin
            drop_q <= 1'b1;
        end
    end

    // Valid bits: invalidate wins over a fill landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (inv_i) begin
            valid_q <= '0;
        end else if (fill_we && !drop_q) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays take the returned line whether or not it is
    // marked valid.
    always_ff @(posedge clk) begin
        // NOTE: the arrays have no reset; the valid bits alone decide
        // whether their contents are used, which keeps them plain RAM.
        if (fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= ext_data_i;
        end
    end

    assign ext_req_o  = (state_q == ST_REQ);
    assign ext_addr_o = {fill_line_q, 2'b00};
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: doc/srv_icache.md
# srv_icache

Direct-mapped instruction cache with a line-refill controller. It sits between the schoolRISCV fetch stage and the instruction memory line port. It serves word fetches from a local line store and, on a miss, acts as the initiator of the 128-bit line-fill protocol (`ext_req` / `ext_rsp`). It then writes the returned line and resumes lookup.

## Interface
Parameters:
- `LINES`, 16, number of cache lines; power of two, ≥2. `IDX_W = log2(LINES)`, `TAG_W = 30 - IDX_W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req_i`  in  1  fetch request this cycle.
- `cpu_addr_i`  in  32  word address (PC >> 2).
- `cpu_valid_o`  out  1  hit; `cpu_rdata_o` valid this cycle.
- `cpu_rdata_o`  out  32  fetched instruction word; 0 when `cpu_valid_o`=0.
- `cpu_stall_o`  out  1  `cpu_req_i & ~cpu_valid_o`.
- `inv_i`  in  1  invalidate all lines (e.g. after `fence.i`).
- `ext_req_o`  out  1  line-fill request; single-cycle pulse.
- `ext_addr_o`  out  32  line-aligned word address `{addr[31:2],2'b00}`; held stable from the request until the response.
- `ext_rsp_i`  in  1  single-cycle pulse; `ext_data_i` is valid in the same cycle.
- `ext_data_i`  in  128  line data; word *k* is at `[32k+:32]`.
- `miss_cnt_o`  out  16  saturating miss counter.

## Operation
- Address split:
  - word offset `addr[1:0]`
  - index `addr[IDX_W+1:2]`
  - tag `addr[31:IDX_W+2]`
- Storage, per line:
  - `valid` bit (reset to 0)
  - tag (not reset)
  - 128-bit data (not reset)
- Hit: `cpu_req_i & valid[idx] & (tag[idx]==addr tag) & state==IDLE`. This is combinational from `cpu_addr_i`. `cpu_rdata_o = data[idx][offset]`.
- FSM states IDLE, REQ, WAIT:
  - IDLE: on `cpu_req_i` miss, latch the line address into `ext_addr_o`, increment `miss_cnt_o` (saturates at 0xFFFF), and go to REQ. Without a miss, stay in IDLE.
  - REQ: `ext_req_o`=1 for exactly this cycle, then go to WAIT.
  - WAIT: wait an unbounded number of cycles for `ext_rsp_i`. On `ext_rsp_i`, write data and tag into the latched index and go to IDLE. Set `valid` unless the `drop` flag is set or `inv_i` is high in the same cycle.
- `drop` flag: set by `inv_i` while in REQ or WAIT; cleared on entry to IDLE.
- `inv_i` in any state clears all `valid` bits at the next edge.
- `ext_rsp_i` outside WAIT is ignored.
- Only one fill is ever outstanding; there is no new `ext_req_o` before `ext_rsp_i`.
- `cpu_addr_i` may change during a miss. The fill uses the latched address. Lookup resumes in IDLE with whatever address is presented then.
- Reset mid-fill: state goes to IDLE and all valid bits are cleared. A late `ext_rsp_i` is ignored.

## Timing
- Reset values:
  - `ext_req_o`=0
  - `ext_addr_o`=0
  - `cpu_valid_o`=0
  - `cpu_rdata_o`=0
  - `cpu_stall_o`=`cpu_req_i`
  - `miss_cnt_o`=0
  - state IDLE
- Hit latency: 0 cycles (combinational).
- Miss detected in cycle m: `ext_req_o` in m+1. With a responder delay of D cycles after the request, `ext_rsp_i` arrives in m+1+D and the hit follows in m+2+D.
  - With D=10: request in m+1, response in m+11, hit in m+12.
- `cpu_valid_o`=0 in REQ and WAIT, even for addresses that would hit.

## Test plan
- Cold miss: after reset, request addr 0x40 → `ext_req_o` for 1 cycle with `ext_addr_o`=0x40. Responder returns {W3,W2,W1,W0} 10 cycles later → next cycle `cpu_valid_o`=1, `cpu_rdata_o`=W0. Addrs 0x41–0x43 hit with W1–W3, with no new request. `miss_cnt_o`=1.
- Conflict: after filling 0x40, request `0x40 + 4*LINES` (same index) → miss and refill. Returning to 0x40 → miss again. `miss_cnt_o`=3.
- Unaligned miss: request 0x27 → `ext_addr_o`=0x24; after the fill, `cpu_rdata_o`=word 3.
- Invalidate: with 0x40 valid, pulse `inv_i` → the next 0x40 fetch misses. Pulse `inv_i` during WAIT → the line is written, but a refetch of the same address misses again. `inv_i` coincident with `ext_rsp_i` → the line is not valid.
- Reset mid-fill: assert `rst` during WAIT, then deliver `ext_rsp_i` → ignored. `ext_req_o`=0 and `miss_cnt_o`=0. The next fetch issues a fresh request.
- Protocol checks:
  - `ext_req_o` is never high for 2 consecutive cycles.
  - `ext_addr_o` is stable from the request until the response.
  - `ext_addr_o[1:0]`=0.
  - Run a variable responder delay of 1–40 cycles.
